// File: rtl/prng_rr_scheduler.sv
// Round-robin arbiter handing out one fresh value from a shared 4-bit LFSR per grant.
// The block also handles seeding and a warm-up phase after a seed load.
//   state  | meaning
//   S_IDLE | arbitrating; one LFSR step per grant issued
//   S_WARM | post-seed warm-up; LFSR free-runs, no grants, busy high
module prng_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WARMUP  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               seed_load,
  input  logic [3:0]         seed_in,
  output logic [NUM_REQ-1:0] grant,
  output logic               rand_valid,
  output logic [3:0]         rand_out,
  output logic               busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] WARM_INIT = 8'(WARMUP);
  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_REQ - 1);

  typedef enum logic {S_IDLE = 1'b0, S_WARM = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [3:0]         lfsr_q, lfsr_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [3:0]         rand_q, rand_d;
  logic [7:0]         cnt_q, cnt_d;

  logic [3:0]         lfsr_next;
  logic [NUM_REQ-1:0] eligible;
  logic               found_hi, found_lo, win_found;
  logic [PTR_W-1:0]   hi_idx, lo_idx, win_idx;

  assign lfsr_next = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};

  // Two-pass search: indices above the pointer win over the wrapped-around ones.
  always_comb begin
    eligible = req & ~grant_q;
    found_hi = 1'b0;
    found_lo = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found_hi && eligible[j] && (PTR_W'(j) > ptr_q)) begin
        found_hi = 1'b1;
        hi_idx   = PTR_W'(j);
      end
      if (!found_lo && eligible[j] && (PTR_W'(j) <= ptr_q)) begin
        found_lo = 1'b1;
        lo_idx   = PTR_W'(j);
      end
    end
    win_found = found_hi | found_lo;
    win_idx   = found_hi ? hi_idx : lo_idx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (seed_load) begin
      state_d = (WARMUP > 0) ? S_WARM : S_IDLE;
    end else if ((state_q == S_WARM) && (cnt_q == 8'd1)) begin
      state_d = S_IDLE;
    end
  end

  always_comb begin
    busy       = (state_q == S_WARM);
    rand_valid = |grant_q;
    grant      = grant_q;
    rand_out   = rand_q;
  end

  always_comb begin
    lfsr_d  = lfsr_q;
    ptr_d   = ptr_q;
    grant_d = '0;
    rand_d  = rand_q;
    cnt_d   = cnt_q;
    if (seed_load) begin
      // A zero seed would lock the LFSR up, so it maps to 1.
      lfsr_d = (seed_in == 4'd0) ? 4'b0001 : seed_in;
      cnt_d  = WARM_INIT;
    end else if (state_q == S_WARM) begin
      lfsr_d = lfsr_next;
      cnt_d  = cnt_q - 8'd1;
    end else if (win_found) begin
      grant_d = NUM_REQ'(1) << win_idx;
      rand_d  = lfsr_q;
      lfsr_d  = lfsr_next;
      ptr_d   = win_idx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q  <= 4'b0001;
      ptr_q   <= PTR_RST;
      grant_q <= '0;
      rand_q  <= 4'd0;
      cnt_q   <= 8'd0;
    end else begin
      lfsr_q  <= lfsr_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      rand_q  <= rand_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_prng_rr_scheduler.sv
// Directed bench for prng_rr_scheduler: expected grants go into a queue and monitors
// pop and compare them whenever the DUT presents rand_valid.
module tb_prng_rr_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, req_b;
  logic       seed_load, seed_load_b;
  logic [3:0] seed_in, seed_in_b;
  logic [3:0] grant, grant_b;
  logic       rand_valid, rand_valid_b;
  logic [3:0] rand_out, rand_out_b;
  logic       busy, busy_b;

  int checks = 0;
  int errors = 0;

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic [15:0] seen;

  // Hand-derived x^4+x^3+1 sequence starting from 0001.
  logic [3:0] seq [15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                           4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

  always #5 clk = ~clk;

  prng_rr_scheduler #(.NUM_REQ(4), .WARMUP(8)) dut (
    .clk(clk), .rst(rst), .req(req), .seed_load(seed_load), .seed_in(seed_in),
    .grant(grant), .rand_valid(rand_valid), .rand_out(rand_out), .busy(busy)
  );

  prng_rr_scheduler #(.NUM_REQ(4), .WARMUP(0)) dut_nw (
    .clk(clk), .rst(rst), .req(req_b), .seed_load(seed_load_b), .seed_in(seed_in_b),
    .grant(grant_b), .rand_valid(rand_valid_b), .rand_out(rand_out_b), .busy(busy_b)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_a(input logic [3:0] g, input logic [3:0] r);
    q_a.push_back({g, r});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  always @(posedge clk) begin
    #1;
    if (rst) begin
      logic [7:0] e;
      chk("valid_vs_grant", 16'(rand_valid), 16'(grant != 4'd0));
      if (rand_valid) begin
        if (q_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant: got grant %b rand %b, expected no grant", grant, rand_out);
        end else begin
          e = q_a.pop_front();
          chk("sb_grant", 16'(grant), 16'(e[7:4]));
          chk("sb_rand", 16'(rand_out), 16'(e[3:0]));
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst && rand_valid_b) begin
      logic [7:0] e;
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_grant_b: got grant %b rand %b, expected no grant", grant_b, rand_out_b);
      end else begin
        e = q_b.pop_front();
        chk("sb_grant_b", 16'(grant_b), 16'(e[7:4]));
        chk("sb_rand_b", 16'(rand_out_b), 16'(e[3:0]));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; req = '0; seed_load = 1'b0; seed_in = '0;
    req_b = '0; seed_load_b = 1'b0; seed_in_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_grant", 16'(grant), 16'h0);
    chk("rst_valid", 16'(rand_valid), 16'h0);
    chk("rst_rand", 16'(rand_out), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    rst = 1'b1;

    // lone requester: grant every other cycle
    push_a(4'b0001, 4'b0001); push_a(4'b0001, 4'b0010);
    push_a(4'b0001, 4'b0100); push_a(4'b0001, 4'b1001);
    req = 4'b0001;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      chk("lone_alternate", 16'(rand_valid), 16'((i % 2) == 0));
    end
    @(negedge clk); req = '0;
    @(posedge clk); #1;

    // all four requesting: rotation from requester 0
    do_reset();
    push_a(4'b0001, 4'b0001); push_a(4'b0010, 4'b0010); push_a(4'b0100, 4'b0100);
    push_a(4'b1000, 4'b1001); push_a(4'b0001, 4'b0011);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("rr_every_cycle", 16'(rand_valid), 16'h1);
    end
    @(negedge clk); req = '0;
    @(posedge clk); #1;

    // seed 1010 with 8-cycle warm-up; pointer is at 0 so requester 1 is next
    @(negedge clk);
    seed_load = 1'b1; seed_in = 4'b1010; req = 4'b1111;
    push_a(4'b0010, 4'b0001); push_a(4'b0100, 4'b0010);
    @(posedge clk); #1;
    chk("warm_busy_first", 16'(busy), 16'h1);
    chk("warm_grant_first", 16'(grant), 16'h0);
    @(negedge clk); seed_load = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      chk("warm_busy", 16'(busy), 16'h1);
      chk("warm_no_grant", 16'(rand_valid), 16'h0);
    end
    @(posedge clk); #1;
    chk("warm_busy_fall", 16'(busy), 16'h0);
    chk("warm_fall_no_grant", 16'(rand_valid), 16'h0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("post_warm_grant", 16'(rand_valid), 16'h1);
    end
    @(negedge clk); req = '0;
    @(posedge clk); #1;

    // zero seed on the WARMUP=0 instance
    @(negedge clk);
    req_b = 4'b0001;
    q_b.push_back({4'b0001, 4'b0001});
    @(posedge clk); #1;
    @(negedge clk);
    req_b = '0; seed_load_b = 1'b1; seed_in_b = 4'b0000;
    @(posedge clk); #1;
    chk("zero_seed_busy", 16'(busy_b), 16'h0);
    chk("zero_seed_grant", 16'(grant_b), 16'h0);
    @(negedge clk);
    seed_load_b = 1'b0; req_b = 4'b0001;
    q_b.push_back({4'b0001, 4'b0001});
    @(posedge clk); #1;
    chk("zero_seed_busy_after", 16'(busy_b), 16'h0);
    chk("zero_seed_valid", 16'(rand_valid_b), 16'h1);
    @(negedge clk); req_b = '0;

    // full period with two alternating requesters
    do_reset();
    for (int i = 0; i < 16; i++)
      push_a(((i % 2) == 0) ? 4'b0001 : 4'b0010, seq[i % 15]);
    seen = '0;
    req = 4'b0011;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      chk("period_valid", 16'(rand_valid), 16'h1);
      if (i < 15) seen[rand_out] = 1'b1;
    end
    chk("period_distinct", seen, 16'hFFFE);
    @(negedge clk); req = '0;
    @(posedge clk); #1;

    // async reset four cycles into warm-up
    @(negedge clk);
    seed_load = 1'b1; seed_in = 4'b0111; req = 4'b1111;
    @(posedge clk); #1;
    @(negedge clk); seed_load = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("midwarm_busy_before", 16'(busy), 16'h1);
    rst = 1'b0;
    #1;
    chk("midwarm_rst_busy", 16'(busy), 16'h0);
    chk("midwarm_rst_grant", 16'(grant), 16'h0);
    chk("midwarm_rst_rand", 16'(rand_out), 16'h0);
    chk("midwarm_rst_valid", 16'(rand_valid), 16'h0);
    repeat (4) @(negedge clk);
    push_a(4'b0001, 4'b0001);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid", 16'(rand_valid), 16'h1);
    @(negedge clk); req = '0;

    repeat (3) @(negedge clk);
    chk("sb_drain_a", 16'(q_a.size()), 16'h0);
    chk("sb_drain_b", 16'(q_b.size()), 16'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prng_rr_scheduler.md
# prng_rr_scheduler

Round-robin scheduler that shares one 4-bit maximal-length LFSR pseudo-random source among `NUM_REQ` requesters. It arbitrates requests, hands each winner one fresh 4-bit number per grant, and advances the LFSR only when a number is consumed. It also owns seeding and a post-seed warm-up phase. It sits between the random-number datapath and the blocks that consume random values. Every consumer sees a distinct value, and the sequence stays reproducible from a seed.

## Interface
- `NUM_REQ`, default 4: number of requesters (2..8).
- `WARMUP`, default 8: LFSR steps after a seed load before serving (0..255).

- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `req`  in  `NUM_REQ`: request vector; bit i high means requester i wants a number.
- `seed_load`  in  1: single-cycle pulse that loads `seed_in`.
- `seed_in`  in  4: seed value.
- `grant`  out  `NUM_REQ`: one-hot grant (or zero), registered.
- `rand_valid`  out  1: high exactly when `grant` is non-zero.
- `rand_out`  out  4: number delivered to the granted requester, registered.
- `busy`  out  1: high during warm-up; no grants are issued while high.

## Operation
- **LFSR:** 4-bit Fibonacci, x^4+x^3+1. Next state = {s[2:0], s[3]^s[2]}. Period 15, all non-zero values. State 0 is never held.
- **FSM states:** IDLE/SERVE (arbitrating) and WARMUP.
- **Reset values:** state IDLE, lfsr 4'b0001, rr pointer `NUM_REQ`-1 (requester 0 has first priority), `grant` 0, `rand_valid` 0, `rand_out` 0, `busy` 0, warm counter 0.
- **Arbitration** (IDLE, no `seed_load`), at each edge:
  - Eligible set = `req` & ~`grant` (the currently granted requester is masked for one cycle).
  - Winner = first eligible index searching upward from pointer+1, with wrap-around.
  - If a winner exists: `grant` <= onehot(winner), `rand_out` <= lfsr, lfsr <= next, pointer <= winner.
  - Otherwise: `grant` <= 0, and `rand_out` and lfsr hold.
- **Consumption:** exactly one LFSR step per grant. Requester i consumes `rand_out` in the cycle `grant[i]`=1. To take one number, the requester drops `req` on seeing its grant.
- **Seed load** (`seed_load`=1, any state), takes priority over arbitration in that cycle:
  - lfsr <= (`seed_in`==0) ? 4'b0001 : `seed_in`.
  - `grant` <= 0.
  - If `WARMUP`>0: warm counter <= `WARMUP`, state <= WARMUP. Otherwise state stays IDLE.
- **WARMUP:**
  - `busy`=1, `grant`=0.
  - Each cycle: lfsr <= next, counter <= counter-1.
  - When the counter decrements to 0, state <= IDLE.
  - WARMUP therefore lasts exactly `WARMUP` cycles.
  - `seed_load` during WARMUP restarts it with the new seed.
- **Requests during WARMUP** are ignored, not queued. Requesters keep `req` high and are served from the first IDLE edge.

## Timing
- Request-to-grant latency is 1 cycle: `req` high before edge k gives `grant`/`rand_out` valid after edge k.
- Throughput:
  - One number per cycle in aggregate when 2 or more requesters are active.
  - A lone requester holding `req` is granted every other cycle because of the grant mask.
- `busy` rises the cycle after `seed_load` and falls after `WARMUP` cycles. The first possible grant appears the edge after `busy` falls.
- Async reset asserted mid-operation forces all outputs to their reset values immediately. The seed and any warm-up in progress are lost.

## Test plan
- **Reset, lone requester:** reset, then `req`=4'b0001 held → `grant`=0001 on alternating cycles; `rand_out` = 0001, 0010, 0100, 1001.
- **All four requesting:** `req`=4'b1111 held → `grant` rotates 0001, 0010, 0100, 1000, 0001 every cycle; `rand_out` = 0001, 0010, 0100, 1001, 0011.
- **Seed with warm-up:** `seed_load` with `seed_in`=4'b1010, `WARMUP`=8 → `busy` high for 8 cycles with `grant`=0 despite `req`=1111; first `rand_out` = 0001, then 0010.
- **Zero seed:** `seed_in`=0, `WARMUP`=0 → next grant delivers `rand_out`=0001; `busy` never asserts.
- **Period:** 15 consecutive grants deliver all 15 non-zero values with no repeat; the 16th grant returns the first value again.
- **Reset mid-warm-up:** `rst` low 4 cycles into WARMUP → `busy`, `grant`, `rand_out` go to 0 immediately; after release the first grant goes to requester 0 with `rand_out`=0001.
